seg_display_controller: RTL and testbench

SEG_DISPLAY_CONTROLLER -- requirements
Module: seg_display_controller

---
 rtl/seg_display_controller.sv | 122 ++++++++++++
 tb/tb_seg_display_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_controller.sv
// Debounced push buttons select which of four signed byte sources feeds a
// seven-segment driver, either manually or by timed auto-scroll.
module seg_display_controller #(
   parameter int DEBOUNCE = 1_000_000,
   parameter int DWELL    = 50_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_next,
   input  logic        btn_mode,
   input  logic [31:0] src_data,
   input  logic [3:0]  src_valid,
   output logic [7:0]  num,
   output logic [1:0]  src_sel,
   output logic        auto_mode,
   output logic        upd
);

   localparam int DB_W = $clog2(DEBOUNCE);
   localparam int DW_W = $clog2(DWELL);

   typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} mode_t;

   // Bit 0 is the next button, bit 1 the mode button.
   logic [1:0]      btn_raw;
   logic [1:0]      sync_q1;
   logic [1:0]      sync_q2;
   logic [1:0]      deb;
   logic [1:0]      deb_q;
   logic [1:0]      press;
   logic [DB_W-1:0] db_cnt [2];

   mode_t           state;
   mode_t           state_nxt;
   logic [DW_W-1:0] dwell;
   logic [DW_W-1:0] dwell_nxt;
   logic [1:0]      cand;
   logic            cand_ok;
   logic [1:0]      sel_nxt;
   logic            advance;

   assign btn_raw = {btn_mode, btn_next};
   assign press   = deb & ~deb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
         deb     <= '0;
         deb_q   <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync_q1 <= btn_raw;
         sync_q2 <= sync_q1;
         deb_q   <= deb;
         for (int i = 0; i < 2; i++) begin
            if (sync_q2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
               deb[i]    <= sync_q2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Scan downwards so the nearest valid successor is the one that sticks.
   always_comb begin
      cand    = src_sel;
      cand_ok = 1'b0;
      for (int k = 3; k >= 1; k--) begin
         if (src_valid[src_sel + 2'(k)]) begin
            cand    = src_sel + 2'(k);
            cand_ok = 1'b1;
         end
      end
   end

   // A mode press wins over a same-cycle next press or dwell expiry.
   always_comb begin
      state_nxt = state;
      dwell_nxt = dwell;
      advance   = 1'b0;
      sel_nxt   = src_sel;
      if (press[1]) begin
         state_nxt = (state == MANUAL) ? AUTO : MANUAL;
         dwell_nxt = '0;
      end else if (press[0]) begin
         advance   = 1'b1;
         dwell_nxt = '0;
      end else if (state == AUTO) begin
         if (dwell == DW_W'(DWELL - 1)) begin
            advance   = 1'b1;
            dwell_nxt = '0;
         end else begin
            dwell_nxt = dwell + 1'b1;
         end
      end
      if (advance && cand_ok) sel_nxt = cand;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= MANUAL;
         dwell     <= '0;
         src_sel   <= '0;
         auto_mode <= 1'b0;
         upd       <= 1'b0;
         num       <= '0;
      end else begin
         state     <= state_nxt;
         dwell     <= dwell_nxt;
         src_sel   <= sel_nxt;
         auto_mode <= (state_nxt == AUTO);
         upd       <= (sel_nxt != src_sel);
         if (src_valid[src_sel]) num <= src_data[{src_sel, 3'b000} +: 8];
      end
   end

endmodule

// File: tb/tb_seg_display_controller.sv
// Bench for seg_display_controller: constant tables, directed corner
// sequences and random stimulus against a cycle-level reference model.
module tb_seg_display_controller;

   localparam int DB = 4;
   localparam int DW = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        btn_next = 1'b0;
   logic        btn_mode = 1'b0;
   logic [31:0] src_data = '0;
   logic [3:0]  src_valid = '0;
   logic [7:0]  num;
   logic [1:0]  src_sel;
   logic        auto_mode;
   logic        upd;

   int n_vec = 0;
   int n_err = 0;
   int ups   = 0;

   seg_display_controller #(.DEBOUNCE(DB), .DWELL(DW)) dut (
      .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_mode(btn_mode),
      .src_data(src_data), .src_valid(src_valid), .num(num),
      .src_sel(src_sel), .auto_mode(auto_mode), .upd(upd)
   );

   always #5 clk = ~clk;

   // Reference model: a button level is accepted once DB consecutive
   // synchronized samples disagree with it; dwell is edges since last clear.
   logic [7:0] m_num;
   logic [1:0] m_sel;
   logic       m_auto, m_upd;
   logic [1:0] m_deb, m_press;
   logic [1:0] raw_q[$];
   logic [1:0] sq[$];
   int         m_cyc, m_mark;

   always @(posedge clk or negedge rst_n) begin : ref_model
      logic [1:0] s;
      int os;
      bit adv, found, diff;
      if (!rst_n) begin
         m_num = '0; m_sel = '0; m_auto = 1'b0; m_upd = 1'b0;
         m_deb = '0; m_press = '0; m_cyc = 0; m_mark = 0;
         raw_q.delete(); sq.delete();
      end else begin
         m_cyc++;
         os = int'(m_sel);
         if (src_valid[os]) m_num = src_data[os*8 +: 8];
         adv = 0;
         if (m_press[1]) begin
            m_auto = !m_auto; m_mark = m_cyc;
         end else if (m_press[0]) begin
            adv = 1; m_mark = m_cyc;
         end else if (m_auto && (m_cyc - m_mark == DW)) begin
            adv = 1; m_mark = m_cyc;
         end
         found = 0;
         if (adv)
            for (int k = 1; k <= 3; k++)
               if (!found && src_valid[(os + k) % 4]) begin
                  m_sel = 2'((os + k) % 4); found = 1;
               end
         m_upd = (int'(m_sel) != os);
         raw_q.push_back({btn_mode, btn_next});
         if (raw_q.size() > 4) void'(raw_q.pop_front());
         s = (raw_q.size() >= 3) ? raw_q[raw_q.size() - 3] : 2'b00;
         sq.push_back(s);
         if (sq.size() > DB) void'(sq.pop_front());
         for (int b = 0; b < 2; b++) begin
            m_press[b] = 1'b0;
            diff = (sq.size() == DB);
            for (int i = 0; i < sq.size(); i++)
               if (sq[i][b] == m_deb[b]) diff = 0;
            if (diff) begin
               m_deb[b] = s[b];
               m_press[b] = s[b];
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (upd === 1'b1) ups++;
      chk("model", {20'd0, num, src_sel, auto_mode, upd},
          {20'd0, m_num, m_sel, m_auto, m_upd});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; btn_next = 1'b0; btn_mode = 1'b0;
      #1;
      chk("reset_outputs", {20'd0, num, src_sel, auto_mode, upd}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ups = 0;
   endtask

   task automatic press_next();
      btn_next = 1'b1;
      repeat (8) step();
      btn_next = 1'b0;
      repeat (8) step();
   endtask

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic [7:0]  exp_num;
   } vec_t;
   vec_t tbl[7];

   initial begin
      int n, first_up, lvl[2], hold[2];
      int t[$];
      logic [1:0] sv[$];

      tbl[0] = '{4'b0001, 32'h0000_0080, 8'h80};
      tbl[1] = '{4'b0001, 32'h0000_007f, 8'h7f};
      tbl[2] = '{4'b1111, 32'h1234_56ff, 8'hff};
      tbl[3] = '{4'b1110, 32'h0000_0011, 8'hff};
      tbl[4] = '{4'b0000, 32'h0000_0022, 8'hff};
      tbl[5] = '{4'b0001, 32'hffff_ff00, 8'h00};
      tbl[6] = '{4'b0101, 32'h00aa_0033, 8'h33};

      // Pass-through of the selected byte, sign bit included; holds when invalid.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         src_valid = tbl[i].valid;
         src_data  = tbl[i].data;
         step();
         chk("table_num", {24'd0, num}, {24'd0, tbl[i].exp_num});
      end

      // Held next button: exactly one advance after 2 + DB edges plus one.
      src_valid = 4'hf; src_data = 32'h0403_0201;
      do_reset();
      btn_next = 1'b1; first_up = -1;
      for (int i = 0; i < 30; i++) begin
         step();
         if (upd && first_up < 0) first_up = i;
      end
      chk("hold_next_latency", first_up, 6);
      chk("hold_next_upd_count", ups, 1);
      chk("hold_next_sel", {30'd0, src_sel}, 1);
      chk("hold_next_num", {24'd0, num}, 32'h02);
      btn_next = 1'b0;
      repeat (8) step();

      // Bouncing input never settles long enough.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         btn_next = ((i / 2) % 2 == 0);
         step();
      end
      btn_next = 1'b0;
      repeat (10) step();
      chk("bounce_upd_count", ups, 0);
      chk("bounce_sel", {30'd0, src_sel}, 0);

      // Sparse valid mask skips invalid sources and wraps.
      src_valid = 4'b1001;
      do_reset();
      press_next();
      chk("skip_sel_first", {30'd0, src_sel}, 3);
      press_next();
      chk("skip_sel_second", {30'd0, src_sel}, 0);
      chk("skip_upd_count", ups, 2);

      // Auto scroll cadence, then a next press mid-dwell restarts the dwell.
      src_valid = 4'hf;
      do_reset();
      btn_mode = 1'b1; n = 0;
      while (!auto_mode && n < 20) begin step(); n++; end
      chk("auto_enter", {31'd0, auto_mode}, 1);
      btn_mode = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         step();
         if (upd) begin t.push_back(c); sv.push_back(src_sel); end
      end
      chk("auto_adv_count", t.size(), 4);
      for (int i = 0; i < t.size(); i++) begin
         chk("auto_adv_time", t[i], 8 * (i + 1));
         chk("auto_adv_sel", {30'd0, sv[i]}, (i + 1) % 4);
      end
      btn_next = 1'b1; n = 0;
      do begin step(); n++; end while (!upd && n < 20);
      chk("auto_next_latency", n, 7);
      chk("auto_next_sel", {30'd0, src_sel}, 1);
      btn_next = 1'b0; n = 0;
      do begin step(); n++; end while (!upd && n < 20);
      chk("auto_after_next_gap", n, 8);
      chk("auto_after_next_sel", {30'd0, src_sel}, 2);

      // Simultaneous mode and next presses: only the mode toggle happens.
      do_reset();
      btn_next = 1'b1; btn_mode = 1'b1;
      repeat (10) step();
      chk("both_auto", {31'd0, auto_mode}, 1);
      chk("both_sel", {30'd0, src_sel}, 0);
      chk("both_upd_count", ups, 0);
      btn_next = 1'b0; btn_mode = 1'b0;
      repeat (4) step();

      // Invalid current source holds num; async reset mid-dwell clears at once.
      src_valid = 4'hf; src_data = 32'h0403_0201;
      do_reset();
      step(); step();
      chk("hold_num_start", {24'd0, num}, 32'h01);
      src_valid = 4'b1110;
      for (int i = 0; i < 4; i++) begin
         src_data = $urandom;
         step();
         chk("hold_num", {24'd0, num}, 32'h01);
      end
      btn_mode = 1'b1;
      repeat (7) step();
      chk("dwell_auto", {31'd0, auto_mode}, 1);
      btn_mode = 1'b0;
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {20'd0, num, src_sel, auto_mode, upd}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Random buttons, masks, data and occasional async resets.
      do_reset();
      hold[0] = 0; hold[1] = 0; lvl[0] = 0; lvl[1] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int b = 0; b < 2; b++) begin
            if (hold[b] == 0) begin
               lvl[b]  = $urandom_range(0, 1);
               hold[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                      : $urandom_range(5, 14);
            end else begin
               hold[b]--;
            end
         end
         btn_next = lvl[0][0];
         btn_mode = lvl[1][0];
         if ($urandom_range(0, 15) == 0) src_valid = 4'($urandom_range(0, 15));
         src_data = $urandom;
         if ($urandom_range(0, 499) == 0) begin
            #2 rst_n = 1'b0;
            #1 chk("rand_async_reset", {20'd0, num, src_sel, auto_mode, upd}, 32'd0);
            #1 rst_n = 1'b1;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
